// File: rtl/count_value_gen.sv
// 4-bit value source: synchronised single-step buttons, parallel load and divider-driven auto-count.
// Define COUNT_SATURATE_EN to clamp at 0/15 instead of wrapping modulo 16.
module count_value_gen #(
  parameter int unsigned DIV_MAX     = 49999999,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Up_n,
  input  logic       Dn_n,
  input  logic       Load,
  input  logic [3:0] Load_val,
  input  logic       Auto_en,
  input  logic       Dir,
  output logic [3:0] Q,
  output logic       Tick,
  output logic       Wrap
);

  localparam int unsigned DIV_W = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV_MAX);

  typedef enum logic {IDLE, HELD} btn_state_t;

  logic [SYNC_STAGES-1:0] up_sync, dn_sync;
  logic                   up_s, dn_s;
  btn_state_t             up_state, dn_state;
  logic [DIV_W-1:0]       div;

  logic       press_up, press_dn, tick_evt;
  logic       do_up, do_dn;
  logic [3:0] q_next;
  logic       wrap_next;

  assign up_s = up_sync[SYNC_STAGES-1];
  assign dn_s = dn_sync[SYNC_STAGES-1];

  // Press pulses are decoded from the FSM transition so Q moves on the same edge the FSM enters HELD.
  always_comb begin
    press_up = (up_state == IDLE) && !up_s;
    press_dn = (dn_state == IDLE) && !dn_s;
    tick_evt = Auto_en && (div == '0);
  end

  always_comb begin
    do_up     = 1'b0;
    do_dn     = 1'b0;
    q_next    = Q;
    wrap_next = 1'b0;
    if (!Load && !(press_up && press_dn)) begin
      if (press_up || (!press_dn && tick_evt && Dir))
        do_up = 1'b1;
      else if (press_dn || (tick_evt && !Dir))
        do_dn = 1'b1;
    end
    if (Load) begin
      q_next = Load_val;
    end else if (do_up) begin
`ifdef COUNT_SATURATE_EN
      if (Q == 4'hF) wrap_next = 1'b1;
      else           q_next    = Q + 4'd1;
`else
      q_next    = Q + 4'd1;
      wrap_next = (Q == 4'hF);
`endif
    end else if (do_dn) begin
`ifdef COUNT_SATURATE_EN
      if (Q == 4'h0) wrap_next = 1'b1;
      else           q_next    = Q - 4'd1;
`else
      q_next    = Q - 4'd1;
      wrap_next = (Q == 4'h0);
`endif
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      up_sync  <= '1;
      dn_sync  <= '1;
      up_state <= IDLE;
      dn_state <= IDLE;
      div      <= DIV_RELOAD;
      Q        <= '0;
      Tick     <= 1'b0;
      Wrap     <= 1'b0;
    end else begin
      up_sync <= {up_sync[SYNC_STAGES-2:0], Up_n};
      dn_sync <= {dn_sync[SYNC_STAGES-2:0], Dn_n};

      case (up_state)
        IDLE:    if (!up_s) up_state <= HELD;
        HELD:    if (up_s)  up_state <= IDLE;
        default: up_state <= IDLE;
      endcase
      case (dn_state)
        IDLE:    if (!dn_s) dn_state <= HELD;
        HELD:    if (dn_s)  dn_state <= IDLE;
        default: dn_state <= IDLE;
      endcase

      if (!Auto_en)      div <= DIV_RELOAD;
      else if (tick_evt) div <= DIV_RELOAD;
      else               div <= div - 1'b1;

      Tick <= tick_evt;
      Q    <= q_next;
      Wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_count_value_gen.sv
// Directed bench for count_value_gen with DIV_MAX=3, SYNC_STAGES=2; expectations follow COUNT_SATURATE_EN.
module tb_count_value_gen;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Up_n, Dn_n, Load, Auto_en, Dir;
  logic [3:0] Load_val;
  logic [3:0] Q;
  logic       Tick, Wrap;

  int compared   = 0;
  int mismatched = 0;

  count_value_gen #(.DIV_MAX(3), .SYNC_STAGES(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .Up_n(Up_n), .Dn_n(Dn_n),
    .Load(Load), .Load_val(Load_val), .Auto_en(Auto_en), .Dir(Dir),
    .Q(Q), .Tick(Tick), .Wrap(Wrap)
  );

  always #5 Clock = ~Clock;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic load_q(input logic [3:0] v);
    Load = 1'b1; Load_val = v;
    cyc(1);
    Load = 1'b0;
  endtask

  task automatic test_reset;
    compared++;
    if (Q !== 4'd0 || Tick !== 1'b0 || Wrap !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_init: Q=%0d Tick=%0b Wrap=%0b, expected 0/0/0", Q, Tick, Wrap);
    end
    load_q(4'd9);
    compared++;
    if (Q !== 4'd9) begin
      mismatched++;
      $display("FAIL reset_preload: Q=%0d, expected 9", Q);
    end
    Resetn = 1'b0;
    #1;
    compared++;
    if (Q !== 4'd0 || Tick !== 1'b0 || Wrap !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async: Q=%0d Tick=%0b Wrap=%0b, expected 0/0/0", Q, Tick, Wrap);
    end
    cyc(1);
    Resetn = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_press;
    load_q(4'd3);
    Up_n = 1'b0;
    cyc(2);
    compared++;
    if (Q !== 4'd3) begin
      mismatched++;
      $display("FAIL press_latency_early: Q=%0d, expected 3", Q);
    end
    cyc(1);
    compared++;
    if (Q !== 4'd4 || Wrap !== 1'b0 || Tick !== 1'b0) begin
      mismatched++;
      $display("FAIL press_step: Q=%0d Wrap=%0b Tick=%0b, expected 4/0/0", Q, Wrap, Tick);
    end
    cyc(17);
    compared++;
    if (Q !== 4'd4) begin
      mismatched++;
      $display("FAIL press_hold: Q=%0d, expected 4", Q);
    end
    Up_n = 1'b1;
    cyc(5);
    compared++;
    if (Q !== 4'd4) begin
      mismatched++;
      $display("FAIL press_release: Q=%0d, expected 4", Q);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_q;
    load_q(4'd15);
    Up_n = 1'b0;
    cyc(3);
`ifdef COUNT_SATURATE_EN
    exp_q = 4'd15;
`else
    exp_q = 4'd0;
`endif
    compared++;
    if (Q !== exp_q || Wrap !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_up: Q=%0d Wrap=%0b, expected %0d/1", Q, Wrap, exp_q);
    end
    Up_n = 1'b1;
    cyc(1);
    compared++;
    if (Wrap !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_up_pulse: Wrap=%0b, expected 0", Wrap);
    end
    cyc(2);
    load_q(4'd0);
    Dn_n = 1'b0;
    cyc(3);
`ifdef COUNT_SATURATE_EN
    exp_q = 4'd0;
`else
    exp_q = 4'd15;
`endif
    compared++;
    if (Q !== exp_q || Wrap !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_dn: Q=%0d Wrap=%0b, expected %0d/1", Q, Wrap, exp_q);
    end
    Dn_n = 1'b1;
    cyc(1);
    compared++;
    if (Wrap !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_dn_pulse: Wrap=%0b, expected 0", Wrap);
    end
    cyc(2);
  endtask

  task automatic test_auto_count;
    logic [3:0] exp_seq [4];
    logic [3:0] prev;
    logic       exp_wrap;
`ifdef COUNT_SATURATE_EN
    exp_seq = '{4'd1, 4'd0, 4'd0, 4'd0};
`else
    exp_seq = '{4'd1, 4'd0, 4'd15, 4'd14};
`endif
    load_q(4'd2);
    prev = 4'd2;
    Dir = 1'b0;
    Auto_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(3);
      compared++;
      if (Tick !== 1'b0 || Q !== prev) begin
        mismatched++;
        $display("FAIL auto_gap%0d: Q=%0d Tick=%0b, expected %0d/0", i, Q, Tick, prev);
      end
      cyc(1);
`ifdef COUNT_SATURATE_EN
      exp_wrap = (prev == 4'd0);
`else
      exp_wrap = (prev == 4'd0);
`endif
      compared++;
      if (Q !== exp_seq[i] || Tick !== 1'b1 || Wrap !== exp_wrap) begin
        mismatched++;
        $display("FAIL auto_tick%0d: Q=%0d Tick=%0b Wrap=%0b, expected %0d/1/%0b",
                 i, Q, Tick, Wrap, exp_seq[i], exp_wrap);
      end
      prev = exp_seq[i];
    end
    Auto_en = 1'b0;
    cyc(6);
    compared++;
    if (Tick !== 1'b0 || Q !== prev) begin
      mismatched++;
      $display("FAIL auto_disabled: Q=%0d Tick=%0b, expected %0d/0", Q, Tick, prev);
    end
  endtask

  task automatic test_load_priority;
    load_q(4'd5);
    Dir = 1'b1;
    Auto_en = 1'b1;
    cyc(1);
    Up_n = 1'b0;
    cyc(2);
    Load = 1'b1; Load_val = 4'd12;
    cyc(1);
    Load = 1'b0;
    compared++;
    if (Q !== 4'd12 || Wrap !== 1'b0 || Tick !== 1'b1) begin
      mismatched++;
      $display("FAIL load_priority: Q=%0d Wrap=%0b Tick=%0b, expected 12/0/1", Q, Wrap, Tick);
    end
    Auto_en = 1'b0;
    Up_n = 1'b1;
    cyc(4);
    compared++;
    if (Q !== 4'd12) begin
      mismatched++;
      $display("FAIL load_after: Q=%0d, expected 12", Q);
    end
  endtask

  task automatic test_cancel;
    load_q(4'd7);
    Dir = 1'b1;
    Auto_en = 1'b1;
    cyc(1);
    Up_n = 1'b0; Dn_n = 1'b0;
    cyc(3);
    compared++;
    if (Q !== 4'd7 || Tick !== 1'b1 || Wrap !== 1'b0) begin
      mismatched++;
      $display("FAIL cancel: Q=%0d Tick=%0b Wrap=%0b, expected 7/1/0", Q, Tick, Wrap);
    end
    Auto_en = 1'b0;
    Up_n = 1'b1; Dn_n = 1'b1;
    cyc(4);
    compared++;
    if (Q !== 4'd7) begin
      mismatched++;
      $display("FAIL cancel_after: Q=%0d, expected 7", Q);
    end
  endtask

  task automatic test_back_to_back;
    load_q(4'd8);
    for (int i = 0; i < 2; i++) begin
      Dn_n = 1'b0;
      cyc(3);
      Dn_n = 1'b1;
      cyc(3);
    end
    compared++;
    if (Q !== 4'd6) begin
      mismatched++;
      $display("FAIL back_to_back_dn: Q=%0d, expected 6", Q);
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Up_n = 1'b1; Dn_n = 1'b1;
    Load = 1'b0; Load_val = '0;
    Auto_en = 1'b0; Dir = 1'b1;
    cyc(2);
    Resetn = 1'b1;
    cyc(1);
    test_reset;
    test_single_press;
    test_wrap;
    test_auto_count;
    test_load_priority;
    test_cancel;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
